// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle FSM and the shared datapath.
// The master modport belongs to the controller; the slave modport belongs to the datapath.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;
  logic       is_halted;

  modport master (
    input  opcode, bcond, halt_cond,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, pc_source, is_halted
  );

  modport slave (
    output opcode, bcond, halt_cond,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, pc_source, is_halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences IF/ID/EX/MEM/WB over the shared datapath
// and drives every enable and mux select from the current state and opcode.
module multicycle_controller (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctl
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_PC_INC = 3'd5, S_HALT = 3'd6, S_BAD = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic   is_halted_q, is_halted_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IF;
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_halted_q <= is_halted_d;
    end
  end

  always_comb begin
    state_d     = S_IF;
    is_halted_d = is_halted_q | (state_q == S_HALT);
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (ctl.opcode)
          OP_ECALL: state_d = ctl.halt_cond ? S_HALT : S_PC_INC;
          OP_R, OP_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          default: state_d = S_PC_INC;
        endcase
      end
      S_EX: begin
        case (ctl.opcode)
          OP_R, OP_IMM, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:     state_d = S_MEM;
          OP_BRANCH:             state_d = ctl.bcond ? S_IF : S_PC_INC;
          default:               state_d = S_IF;
        endcase
      end
      S_MEM:    state_d = (ctl.opcode == OP_LOAD) ? S_WB : S_IF;
      S_WB:     state_d = S_IF;
      S_PC_INC: state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    ctl.pc_write  = 1'b0;
    ctl.i_or_d    = 1'b0;
    ctl.mem_read  = 1'b0;
    ctl.mem_write = 1'b0;
    ctl.ir_write  = 1'b0;
    ctl.reg_write = 1'b0;
    ctl.wb_sel    = 2'd0;
    ctl.alu_src_a = 1'b0;
    ctl.alu_src_b = 2'd0;
    ctl.alu_op    = 2'd0;
    ctl.pc_source = 1'b0;
    ctl.is_halted = is_halted_q;
    case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = 1'b1;
      end
      S_ID: ctl.alu_src_b = 2'd2;
      S_EX: begin
        case (ctl.opcode)
          OP_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = 2'd2;
          end
          OP_IMM: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'd2;
            ctl.alu_op    = 2'd2;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'd2;
          end
          OP_BRANCH: begin
            // Taken branch loads the ID-computed target held in ALUOut.
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = 2'd1;
            ctl.pc_write  = ctl.bcond;
            ctl.pc_source = 1'b1;
          end
          OP_JAL: begin
            ctl.alu_src_b = 2'd1;
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = 2'd2;
            ctl.pc_write  = 1'b1;
            ctl.pc_source = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctl.i_or_d = 1'b1;
        if (ctl.opcode == OP_LOAD) begin
          ctl.mem_read = 1'b1;
        end else if (ctl.opcode == OP_STORE) begin
          ctl.mem_write = 1'b1;
          ctl.alu_src_b = 2'd1;
          ctl.pc_write  = 1'b1;
        end
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src_b = 2'd1;
        ctl.pc_write  = 1'b1;
        if (ctl.opcode == OP_LOAD) begin
          ctl.wb_sel = 2'd1;
        end else if (ctl.opcode == OP_JALR) begin
          ctl.wb_sel    = 2'd2;
          ctl.pc_source = 1'b1;
        end
      end
      S_PC_INC: begin
        ctl.alu_src_b = 2'd1;
        ctl.pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every strobe in the same cycle it is sampled.
    if (reset) begin
      ctl.pc_write  = 1'b0;
      ctl.i_or_d    = 1'b0;
      ctl.mem_read  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.reg_write = 1'b0;
      ctl.wb_sel    = 2'd0;
      ctl.alu_src_a = 1'b0;
      ctl.alu_src_b = 2'd0;
      ctl.alu_op    = 2'd0;
      ctl.pc_source = 1'b0;
      ctl.is_halted = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each stimulus cycle queues the
// expected control word, a monitor pops and compares it on the falling edge.
module tb_multicycle_controller;
  logic clk;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          step;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // {pc_write,i_or_d,mem_read,mem_write,ir_write,reg_write,wb_sel,
  //  alu_src_a,alu_src_b,alu_op,pc_source,is_halted}
  function automatic logic [15:0] mk(input logic pcw, input logic iod, input logic mr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic [1:0] wb, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic pcs, input logic hlt);
    return {pcw, iod, mr, mw, irw, rw, wb, asa, asb, aop, pcs, hlt};
  endfunction

  logic [15:0] e_zero, e_if, e_id, e_ex_r, e_ex_imm, e_ex_ls, e_ex_bt, e_ex_bn, e_ex_jal;
  logic [15:0] e_mem_ld, e_mem_st, e_wb_r, e_wb_ld, e_wb_jalr, e_pc_inc, e_halt0, e_halt1;

  initial begin
    e_zero    = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    e_if      = mk(0,0,1,0,1,0,2'd0,0,2'd0,2'd0,0,0);
    e_id      = mk(0,0,0,0,0,0,2'd0,0,2'd2,2'd0,0,0);
    e_ex_r    = mk(0,0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0);
    e_ex_imm  = mk(0,0,0,0,0,0,2'd0,1,2'd2,2'd2,0,0);
    e_ex_ls   = mk(0,0,0,0,0,0,2'd0,1,2'd2,2'd0,0,0);
    e_ex_bt   = mk(1,0,0,0,0,0,2'd0,1,2'd0,2'd1,1,0);
    e_ex_bn   = mk(0,0,0,0,0,0,2'd0,1,2'd0,2'd1,1,0);
    e_ex_jal  = mk(1,0,0,0,0,1,2'd2,0,2'd1,2'd0,1,0);
    e_mem_ld  = mk(0,1,1,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    e_mem_st  = mk(1,1,0,1,0,0,2'd0,0,2'd1,2'd0,0,0);
    e_wb_r    = mk(1,0,0,0,0,1,2'd0,0,2'd1,2'd0,0,0);
    e_wb_ld   = mk(1,0,0,0,0,1,2'd1,0,2'd1,2'd0,0,0);
    e_wb_jalr = mk(1,0,0,0,0,1,2'd2,0,2'd1,2'd0,1,0);
    e_pc_inc  = mk(1,0,0,0,0,0,2'd0,0,2'd1,2'd0,0,0);
    e_halt0   = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    e_halt1   = mk(0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1);
  end

  function automatic logic [15:0] dut_word();
    return {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.wb_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.is_halted};
  endfunction

  task automatic cyc(input logic rst, input logic [6:0] op, input logic bc,
                     input logic hc, input logic [15:0] exp_word, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.bcond     = bc;
    bus.halt_cond = hc;
    e.word = exp_word;
    e.step = step_n;
    e.name = name;
    exp_q.push_back(e);
    step_n++;
  endtask

  // Monitor: one comparison per queued cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [15:0] got;
      e = exp_q.pop_front();
      got = dut_word();
      checks++;
      if (got !== e.word) begin
        errors++;
        $display("FAIL step %0d %s: got %h expected %h", e.step, e.name, got, e.word);
      end else begin
        $display("ok   step %0d %s: %h", e.step, e.name, got);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = 7'd0;
    bus.bcond     = 1'b0;
    bus.halt_cond = 1'b0;

    repeat (3) cyc(1, 7'd0, 0, 0, e_zero, "reset");

    cyc(0, OP_R, 0, 0, e_if,   "add_if");
    cyc(0, OP_R, 0, 0, e_id,   "add_id");
    cyc(0, OP_R, 1, 1, e_ex_r, "add_ex");
    cyc(0, OP_R, 0, 0, e_wb_r, "add_wb");

    cyc(0, OP_IMM, 0, 0, e_if,     "imm_if");
    cyc(0, OP_IMM, 0, 0, e_id,     "imm_id");
    cyc(0, OP_IMM, 0, 0, e_ex_imm, "imm_ex");
    cyc(0, OP_IMM, 0, 0, e_wb_r,   "imm_wb");

    cyc(0, OP_LOAD, 0, 0, e_if,     "ld_if");
    cyc(0, OP_LOAD, 0, 0, e_id,     "ld_id");
    cyc(0, OP_LOAD, 0, 0, e_ex_ls,  "ld_ex");
    cyc(0, OP_LOAD, 0, 0, e_mem_ld, "ld_mem");
    cyc(0, OP_LOAD, 0, 0, e_wb_ld,  "ld_wb");

    cyc(0, OP_BRANCH, 0, 0, e_if,    "bt_if");
    cyc(0, OP_BRANCH, 0, 0, e_id,    "bt_id");
    cyc(0, OP_BRANCH, 1, 0, e_ex_bt, "bt_ex");

    cyc(0, OP_BRANCH, 1, 0, e_if,     "bn_if");
    cyc(0, OP_BRANCH, 1, 0, e_id,     "bn_id");
    cyc(0, OP_BRANCH, 0, 0, e_ex_bn,  "bn_ex");
    cyc(0, OP_BRANCH, 0, 0, e_pc_inc, "bn_pcinc");

    cyc(0, OP_JAL, 0, 0, e_if,     "jal_if");
    cyc(0, OP_JAL, 0, 0, e_id,     "jal_id");
    cyc(0, OP_JAL, 0, 0, e_ex_jal, "jal_ex");

    cyc(0, OP_JALR, 0, 0, e_if,      "jalr_if");
    cyc(0, OP_JALR, 0, 0, e_id,      "jalr_id");
    cyc(0, OP_JALR, 0, 0, e_ex_ls,   "jalr_ex");
    cyc(0, OP_JALR, 0, 0, e_wb_jalr, "jalr_wb");

    cyc(0, OP_STORE, 0, 0, e_if,     "st_if");
    cyc(0, OP_STORE, 0, 0, e_id,     "st_id");
    cyc(0, OP_STORE, 0, 0, e_ex_ls,  "st_ex");
    cyc(0, OP_STORE, 0, 0, e_mem_st, "st_mem");

    cyc(0, OP_ECALL, 0, 0, e_if,     "ecall0_if");
    cyc(0, OP_ECALL, 0, 0, e_id,     "ecall0_id");
    cyc(0, OP_ECALL, 0, 0, e_pc_inc, "ecall0_pcinc");

    cyc(0, 7'd0, 0, 1, e_if,     "nop_if");
    cyc(0, 7'd0, 0, 1, e_id,     "nop_id");
    cyc(0, 7'd0, 0, 1, e_pc_inc, "nop_pcinc");

    cyc(0, OP_STORE, 0, 0, e_if,    "strst_if");
    cyc(0, OP_STORE, 0, 0, e_id,    "strst_id");
    cyc(0, OP_STORE, 0, 0, e_ex_ls, "strst_ex");
    cyc(1, OP_STORE, 0, 0, e_zero,  "strst_mem_reset");
    cyc(0, OP_R, 0, 0, e_if,   "post_rst_if");
    cyc(0, OP_R, 0, 0, e_id,   "post_rst_id");
    cyc(0, OP_R, 0, 0, e_ex_r, "post_rst_ex");
    cyc(0, OP_R, 0, 0, e_wb_r, "post_rst_wb");

    cyc(0, OP_ECALL, 0, 1, e_if,    "halt_if");
    cyc(0, OP_ECALL, 0, 1, e_id,    "halt_id");
    cyc(0, OP_ECALL, 0, 1, e_halt0, "halt_enter");
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i % 2 == 0) ? OP_R : OP_JAL, i[0], 0, e_halt1, "halt_hold");
    end

    cyc(1, OP_R, 0, 0, e_zero, "unhalt_reset");
    cyc(0, OP_R, 0, 0, e_if,   "unhalt_if");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
